jelly2_img_frame_sequencer: RTL and testbench
=============================================

# jelly2_img_frame_sequencer

Front-end controller for the image block/line-buffer datapath. It converts an AXI4-Stream video frame (tuser = start-of-frame, tlast = end-of-line) into the `img` bus: `row_first`, `row_last`, `col_first`, `col_last`, `de`, `valid`. It generates these flags from programmed frame dimensions and checks the stream against them. After the last pixel of each frame it issues a programmable run of flush cycles (`valid=1`, `de=0`) so that downstream line/pixel buffers drain their border rows and columns.

## Interface
Parameters:
- `USER_WIDTH`, 0: side-band width passed through to `m_img_user`; port width is `USER_BITS = max(USER_WIDTH,1)`.
- `DATA_WIDTH`, 8: pixel width.
- `X_WIDTH`, 12: column counter and width-register width.
- `Y_WIDTH`, 12: row counter and height-register width.
- `FLUSH_WIDTH`, 16: flush-count register width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `cke`, in, 1: clock enable; all state holds when 0.
- `param_width`, in, `X_WIDTH`: columns per frame, ≥1; latched at SOF acceptance.
- `param_height`, in, `Y_WIDTH`: rows per frame, ≥1; latched at SOF acceptance.
- `param_flush`, in, `FLUSH_WIDTH`: flush cycles after a frame; latched at SOF acceptance.
- `s_axi4s_tuser`, in, 1: start of frame.
- `s_axi4s_tlast`, in, 1: end of line.
- `s_axi4s_tuser_ext`, in, `USER_BITS`: side-band data.
- `s_axi4s_tdata`, in, `DATA_WIDTH`: pixel.
- `s_axi4s_tvalid`, in, 1: beat valid.
- `s_axi4s_tready`, out, 1: beat accepted when `tvalid & tready`.
- `m_img_row_first`, `m_img_row_last`, `m_img_col_first`, `m_img_col_last`, `m_img_de`, out, 1 each: img flags.
- `m_img_user`, out, `USER_BITS`: side-band data.
- `m_img_data`, out, `DATA_WIDTH`: pixel.
- `m_img_valid`, out, 1: img bus valid.
- `busy`, out, 1: state ≠ IDLE.
- `err_sof`, out, 1: one-cycle pulse on an unexpected SOF.
- `err_eol`, out, 1: one-cycle pulse on a tlast mismatch.

## Operation
- States: `IDLE`, `RUN`, `FLUSH`. Reset enters `IDLE`.
- **IDLE**
  - `tready=cke`.
  - Beats with `tuser=0` are discarded and produce no output.
  - A beat with `tuser=1` latches the three params, is emitted as pixel (0,0) with `x=0`, `y=0`, and moves to `RUN`.
  - If the frame is 1×1, go directly to `FLUSH`, or to `IDLE` when `param_flush=0`.
- **RUN**
  - `tready=cke`.
  - Each accepted beat is emitted as one pixel with `de=1`, `valid=1`.
  - Flags: `col_first=(x==0)`, `col_last=(x==W-1)`, `row_first=(y==0)`, `row_last=(y==H-1)`.
  - `x` increments and wraps to 0 at `W-1`; `y` increments on that wrap.
  - After pixel (W-1, H-1): go to `FLUSH` with `fcnt=0`, or to `IDLE` if the latched flush count is 0.
- **FLUSH**
  - `tready=0`.
  - Each `cke` cycle emits `valid=1`, `de=0`; flags and data hold their previous values.
  - `fcnt` increments; after `F` cycles the state returns to `IDLE`.
- **Unexpected SOF**: `tuser=1` accepted in `RUN` at a position other than (0,0), or `tuser=1` together with `x|y≠0`.
  - `err_sof` pulses.
  - The params are re-latched and the beat becomes pixel (0,0) of a new frame.
  - There is no flush for the aborted frame.
- **tlast mismatch**: `tlast≠(x==W-1)` on an accepted RUN/IDLE-SOF beat pulses `err_eol`. Counters follow the params, never `tlast`.
- Side-band and data are registered with the pixel. Flags are computed from the counters before they increment.

## Timing
- All outputs are registered.
- Output latency is 1 `cke` cycle from beat acceptance to `m_img_*`.
- No-output cycles with `cke=1` drive `m_img_valid=0`, `de=0`.
- With `cke=0`, all registers (including outputs, counters and state) hold, and `tready=0`.
- Reset values: all `m_img_*`, `busy`, `err_*` are 0; `x`, `y`, `fcnt` are 0; state is `IDLE`.
- `tready` is combinational from state and `cke` only; it never depends on `tvalid`.
- A reset asserted mid-frame or mid-flush aborts immediately. The next cycle shows reset values, and no further flush is issued.
- Back-to-back frames: an SOF can be accepted on the cycle `FLUSH` exits to `IDLE`, i.e. with 0 bubble after the last flush cycle's output.
- Maximum throughput is 1 pixel per `cke` cycle in `RUN`.

## Test plan
- **4×3 frame, flush=2, tvalid always 1**: 12 outputs with `de=1`; `col_first` at x=0, `col_last` at x=3, `row_first` on outputs 0–3, `row_last` on 8–11. Then 2 cycles with `valid=1`, `de=0` and `tready=0`. `busy` falls after those.
- **Same frame with random `tvalid` gaps and `cke` toggling**: identical pixel/flag sequence. `m_img_valid` is 0 on gaps, and outputs freeze while `cke=0`.
- **Garbage beats (tuser=0) in IDLE, then SOF**: garbage produces no output. SOF data appears as the first pixel with `row_first=col_first=1`.
- **SOF injected at pixel (2,1) of a 4×3 frame**: `err_sof` pulses once, the injected pixel is emitted as (0,0), the new frame completes with 12 pixels, and the aborted frame gets no flush.
- **tlast asserted at x=1 in a width-4 frame**: `err_eol` pulses once and `col_last` still appears at x=3.
- **1×1 frame, flush=0, then reset asserted mid-flush of a 4×3/flush=5 frame**: single pixel with all four flags set, returning directly to IDLE; the reset clears outputs the next cycle and `busy=0`.

Source files
------------

// File: rtl/jelly2_img_frame_sequencer.sv
// ---------------------------------------------------------------------------
// jelly2_img_frame_sequencer
//
// Turns an AXI4-Stream video frame (tuser = start of frame, tlast = end of
// line) into the img bus used by the line/pixel buffer datapath.  Position
// flags come from internal column/row counters driven by the programmed
// frame size, so a malformed stream can never desynchronise the img bus.
// After every complete frame a programmable run of flush cycles
// (valid=1, de=0) lets the downstream buffers drain their border pixels.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   cke                  clock enable, every register holds while low
//   param_width/height   frame size in pixels, latched when a frame starts
//   param_flush          number of flush cycles after a frame, latched too
//   s_axi4s_*            incoming video stream
//   m_img_*              registered img bus, one cycle behind acceptance
//   busy                 high whenever the sequencer is not idle
//   err_sof / err_eol    one-cycle pulses on a misplaced SOF / tlast
// ---------------------------------------------------------------------------
module jelly2_img_frame_sequencer #(
    parameter int USER_WIDTH  = 0,
    parameter int DATA_WIDTH  = 8,
    parameter int X_WIDTH     = 12,
    parameter int Y_WIDTH     = 12,
    parameter int FLUSH_WIDTH = 16,
    parameter int USER_BITS   = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cke,

    input  logic [X_WIDTH-1:0]      param_width,
    input  logic [Y_WIDTH-1:0]      param_height,
    input  logic [FLUSH_WIDTH-1:0]  param_flush,

    input  logic                    s_axi4s_tuser,
    input  logic                    s_axi4s_tlast,
    input  logic [USER_BITS-1:0]    s_axi4s_tuser_ext,
    input  logic [DATA_WIDTH-1:0]   s_axi4s_tdata,
    input  logic                    s_axi4s_tvalid,
    output logic                    s_axi4s_tready,

    output logic                    m_img_row_first,
    output logic                    m_img_row_last,
    output logic                    m_img_col_first,
    output logic                    m_img_col_last,
    output logic                    m_img_de,
    output logic [USER_BITS-1:0]    m_img_user,
    output logic [DATA_WIDTH-1:0]   m_img_data,
    output logic                    m_img_valid,

    output logic                    busy,
    output logic                    err_sof,
    output logic                    err_eol
);

    localparam logic [X_WIDTH-1:0]     X_ONE = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0]     Y_ONE = Y_WIDTH'(1);
    localparam logic [FLUSH_WIDTH-1:0] F_ONE = FLUSH_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t                     state;
    logic [X_WIDTH-1:0]         x;
    logic [Y_WIDTH-1:0]         y;
    logic [FLUSH_WIDTH-1:0]     fcnt;
    logic [X_WIDTH-1:0]         reg_width;
    logic [Y_WIDTH-1:0]         reg_height;
    logic [FLUSH_WIDTH-1:0]     reg_flush;

    logic                       new_frame;
    logic                       take_beat;
    logic [X_WIDTH-1:0]         cur_w;
    logic [Y_WIDTH-1:0]         cur_h;
    logic [FLUSH_WIDTH-1:0]     cur_flush;
    logic [X_WIDTH-1:0]         cur_x;
    logic [Y_WIDTH-1:0]         cur_y;
    logic                       cur_col_last;
    logic                       cur_row_last;

    // The stream is stalled only while flushing; tready never looks at tvalid.
    assign s_axi4s_tready = cke && (state != ST_FLUSH);
    assign busy           = (state != ST_IDLE);

    // Geometry that applies to the beat currently offered.  An SOF beat
    // always starts a fresh frame at (0,0) using the live parameters, so the
    // flags of that very pixel already reflect the new frame size.
    always_comb begin
        new_frame    = s_axi4s_tuser;
        cur_w        = new_frame ? param_width  : reg_width;
        cur_h        = new_frame ? param_height : reg_height;
        cur_flush    = new_frame ? param_flush  : reg_flush;
        cur_x        = new_frame ? '0 : x;
        cur_y        = new_frame ? '0 : y;
        cur_col_last = (cur_x == cur_w - X_ONE);
        cur_row_last = (cur_y == cur_h - Y_ONE);
        // In IDLE only an SOF beat is turned into a pixel; others are dropped.
        take_beat    = s_axi4s_tvalid && s_axi4s_tready &&
                       ((state == ST_RUN) || ((state == ST_IDLE) && s_axi4s_tuser));
    end

    // Single state machine that owns counters, latched parameters and the
    // registered img outputs.  Flags and data are held during flush and gap
    // cycles; only valid/de/err are refreshed every enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            x               <= '0;
            y               <= '0;
            fcnt            <= '0;
            reg_width       <= '0;
            reg_height      <= '0;
            reg_flush       <= '0;
            m_img_row_first <= 1'b0;
            m_img_row_last  <= 1'b0;
            m_img_col_first <= 1'b0;
            m_img_col_last  <= 1'b0;
            m_img_de        <= 1'b0;
            m_img_user      <= '0;
            m_img_data      <= '0;
            m_img_valid     <= 1'b0;
            err_sof         <= 1'b0;
            err_eol         <= 1'b0;
        end else if (cke) begin
            m_img_valid <= 1'b0;
            m_img_de    <= 1'b0;
            err_sof     <= 1'b0;
            err_eol     <= 1'b0;

            if (take_beat) begin
                m_img_valid     <= 1'b1;
                m_img_de        <= 1'b1;
                m_img_row_first <= (cur_y == '0);
                m_img_row_last  <= cur_row_last;
                m_img_col_first <= (cur_x == '0);
                m_img_col_last  <= cur_col_last;
                m_img_user      <= s_axi4s_tuser_ext;
                m_img_data      <= s_axi4s_tdata;

                // An SOF mid-frame aborts the old frame without any flush.
                err_sof <= s_axi4s_tuser && (state == ST_RUN) && ((x != '0) || (y != '0));
                err_eol <= (s_axi4s_tlast != cur_col_last);

                if (new_frame) begin
                    reg_width  <= param_width;
                    reg_height <= param_height;
                    reg_flush  <= param_flush;
                end

                // Counters follow the programmed size, never tlast.
                if (cur_col_last) begin
                    x <= '0;
                    if (cur_row_last) begin
                        y     <= '0;
                        fcnt  <= '0;
                        state <= (cur_flush == '0) ? ST_IDLE : ST_FLUSH;
                    end else begin
                        y     <= cur_y + Y_ONE;
                        state <= ST_RUN;
                    end
                end else begin
                    x     <= cur_x + X_ONE;
                    y     <= cur_y;
                    state <= ST_RUN;
                end
            end else if (state == ST_FLUSH) begin
                m_img_valid <= 1'b1;
                if (fcnt == reg_flush - F_ONE) begin
                    fcnt  <= '0;
                    state <= ST_IDLE;
                end else begin
                    fcnt <= fcnt + F_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_jelly2_img_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jelly2_img_frame_sequencer
//
// Scoreboard bench: every accepted beat pushes the img word it should
// produce, flush words are pushed once a frame's last beat is taken, and a
// negedge monitor pops and compares whenever the DUT presents output.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jelly2_img_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cke = 1'b1;
    logic [11:0] param_width = 12'd4;
    logic [11:0] param_height = 12'd3;
    logic [15:0] param_flush = 16'd0;
    logic        s_axi4s_tuser = 1'b0;
    logic        s_axi4s_tlast = 1'b0;
    logic [0:0]  s_axi4s_tuser_ext = 1'b0;
    logic [7:0]  s_axi4s_tdata = 8'h00;
    logic        s_axi4s_tvalid = 1'b0;
    logic        s_axi4s_tready;
    logic        m_img_row_first;
    logic        m_img_row_last;
    logic        m_img_col_first;
    logic        m_img_col_last;
    logic        m_img_de;
    logic [0:0]  m_img_user;
    logic [7:0]  m_img_data;
    logic        m_img_valid;
    logic        busy;
    logic        err_sof;
    logic        err_eol;

    int          numChecks = 0;
    int          numFails = 0;
    logic [31:0] expQ[$];
    bit          ckeRand = 1'b0;
    bit          prevCke = 1'b1;
    bit          prevRst = 1'b1;
    logic        snapValid = 1'b0;
    logic [31:0] snapPix = 32'd0;
    logic [31:0] monObs;

    jelly2_img_frame_sequencer #(
        .USER_WIDTH  (0),
        .DATA_WIDTH  (8),
        .X_WIDTH     (12),
        .Y_WIDTH     (12),
        .FLUSH_WIDTH (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cke               (cke),
        .param_width       (param_width),
        .param_height      (param_height),
        .param_flush       (param_flush),
        .s_axi4s_tuser     (s_axi4s_tuser),
        .s_axi4s_tlast     (s_axi4s_tlast),
        .s_axi4s_tuser_ext (s_axi4s_tuser_ext),
        .s_axi4s_tdata     (s_axi4s_tdata),
        .s_axi4s_tvalid    (s_axi4s_tvalid),
        .s_axi4s_tready    (s_axi4s_tready),
        .m_img_row_first   (m_img_row_first),
        .m_img_row_last    (m_img_row_last),
        .m_img_col_first   (m_img_col_first),
        .m_img_col_last    (m_img_col_last),
        .m_img_de          (m_img_de),
        .m_img_user        (m_img_user),
        .m_img_data        (m_img_data),
        .m_img_valid       (m_img_valid),
        .busy              (busy),
        .err_sof           (err_sof),
        .err_eol           (err_eol)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Clock enable driver: solid high normally, randomly dropped when enabled.
    always begin
        @(posedge clk);
        #1;
        cke = ckeRand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Pack one img word: de, row_first, row_last, col_first, col_last,
    // err_sof, err_eol, user, data.
    function automatic logic [31:0] pixExp(input logic de, input logic rf, input logic rl,
                                           input logic cf, input logic cl, input logic es,
                                           input logic ee, input logic user, input logic [7:0] d);
        return {16'd0, de, rf, rl, cf, cl, es, ee, user, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        numChecks++;
        if (obs !== expv) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Monitor: on a fresh enabled cycle compare the output against the
    // scoreboard; while cke was low everything must stay frozen.
    always @(negedge clk) begin
        monObs = pixExp(m_img_de, m_img_row_first, m_img_row_last, m_img_col_first,
                        m_img_col_last, err_sof, err_eol, m_img_user[0], m_img_data);
        if (!prevRst) begin
            if (!prevCke) begin
                checkOutput("freeze_valid", {31'd0, m_img_valid}, {31'd0, snapValid});
                checkOutput("freeze_pix", monObs, snapPix);
            end else if (m_img_valid) begin
                if (expQ.size() == 0)
                    checkOutput("spurious_out", {31'd0, m_img_valid}, 32'd0);
                else
                    checkOutput("pixel", monObs, expQ.pop_front());
            end else begin
                checkOutput("idle_flags", {29'd0, m_img_de, err_sof, err_eol}, 32'd0);
            end
        end
        snapValid = m_img_valid;
        snapPix   = monObs;
        prevCke   = cke;
        prevRst   = reset;
    end

    // Offer one beat until it is taken, recording its expected img word.
    task automatic applyStimulus(input logic tuser, input logic tlast, input logic [7:0] d,
                                 input logic [31:0] expv, input int gaps);
        bit done = 1'b0;
        int budget = 200;
        while (!done && budget > 0) begin
            s_axi4s_tuser     = tuser;
            s_axi4s_tlast     = tlast;
            s_axi4s_tdata     = d;
            s_axi4s_tuser_ext = d[0];
            s_axi4s_tvalid    = (gaps == 0) || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (s_axi4s_tvalid && s_axi4s_tready && cke) begin
                expQ.push_back(expv);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            s_axi4s_tvalid = 1'b0;
            budget--;
        end
        if (!done)
            checkOutput("accept_timeout", {31'd0, done}, 32'd1);
    endtask

    // Send npix pixels of a w x h frame; a complete frame also queues its
    // flush words, which repeat the last pixel's flags and data with de=0.
    task automatic sendFrame(input int w, input int h, input int f, input int gaps,
                             input int npix, input int sofErr, input int badIdx,
                             input logic [7:0] base);
        int x = 0;
        int y = 0;
        logic [7:0] d = base;
        logic tl;
        @(posedge clk);
        #1;
        param_width  = 12'(w);
        param_height = 12'(h);
        param_flush  = 16'(f);
        for (int i = 0; i < npix; i++) begin
            x  = i % w;
            y  = i / w;
            d  = base + 8'(i);
            tl = (x == w - 1);
            if (i == badIdx)
                tl = !tl;
            applyStimulus(i == 0, tl, d,
                          pixExp(1'b1, y == 0, y == h - 1, x == 0, x == w - 1,
                                 (i == 0) && (sofErr != 0), i == badIdx, d[0], d),
                          gaps);
        end
        if (npix == w * h) begin
            for (int k = 0; k < f; k++)
                expQ.push_back(pixExp(1'b0, y == 0, y == h - 1, x == 0, x == w - 1,
                                      1'b0, 1'b0, d[0], d));
        end
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, expQ.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case something wedges the simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, failures so far %0d", numFails);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] starting jelly2_img_frame_sequencer bench");

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_img", {24'd0, m_img_valid, m_img_de, m_img_row_first, m_img_row_last,
                                m_img_col_first, m_img_col_last, err_sof, err_eol}, 32'd0);
        checkOutput("rst_data", {23'd0, m_img_user, m_img_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 4x3 frame, flush=2, no gaps; tready low exactly while flushing.
        sendFrame(4, 3, 2, 0, 12, 0, -1, 8'h10);
        @(negedge clk);
        checkOutput("t1_tready_f0", {31'd0, s_axi4s_tready}, 32'd0);
        checkOutput("t1_busy_f0", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("t1_tready_f1", {31'd0, s_axi4s_tready}, 32'd0);
        checkOutput("t1_busy_f1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("t1_tready_end", {31'd0, s_axi4s_tready}, 32'd1);
        checkOutput("t1_busy_end", {31'd0, busy}, 32'd0);
        waitDrain("t1_drain");

        // Same frame with tvalid gaps and cke toggling.
        ckeRand = 1'b1;
        sendFrame(4, 3, 2, 1, 12, 0, -1, 8'h40);
        waitDrain("t2_drain");
        ckeRand = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t2_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // Garbage beats in IDLE are dropped, then a 2x2 frame.
        s_axi4s_tuser  = 1'b0;
        s_axi4s_tdata  = 8'hEE;
        s_axi4s_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_axi4s_tvalid = 1'b0;
        sendFrame(2, 2, 1, 0, 4, 0, -1, 8'h80);
        waitDrain("t3_drain");

        // SOF injected at (2,1): the aborted frame gets no flush.
        sendFrame(4, 3, 1, 0, 6, 0, -1, 8'h20);
        sendFrame(4, 3, 1, 0, 12, 1, -1, 8'h60);
        waitDrain("t4_drain");

        // tlast asserted early at x=1; counters ignore it. flush=0.
        sendFrame(4, 2, 0, 0, 8, 0, 1, 8'hA0);
        @(negedge clk);
        checkOutput("t5_busy", {31'd0, busy}, 32'd0);
        waitDrain("t5_drain");

        // 1x1 frame without flush goes straight back to IDLE.
        sendFrame(1, 1, 0, 0, 1, 0, -1, 8'hC3);
        @(negedge clk);
        checkOutput("t6_busy_1x1", {31'd0, busy}, 32'd0);
        waitDrain("t6_drain");

        // 4x3 / flush=5, reset two cycles into the flush.
        sendFrame(4, 3, 5, 0, 12, 0, -1, 8'hD0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_rst_img", {30'd0, m_img_valid, m_img_de}, 32'd0);
        checkOutput("t6_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_rst_flags", {28'd0, m_img_row_first, m_img_row_last,
                                     m_img_col_first, m_img_col_last}, 32'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("t6_post_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_post_q", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
